// File: rtl/csa_pkg.sv
// Shared types and elaboration-time helpers for the carry-save accumulator.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC     = 2'd1,
    RESOLVE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int acc_w(input int n, input int max_ops);
    return n + clog2(max_ops);
  endfunction

  function automatic int cnt_w(input int max_ops);
    return clog2(max_ops) + 1;
  endfunction

  function automatic int res_cyc(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/csa_accumulator_3to2.sv
// csa_3to2: bitwise 3:2 compressor; cy is the unshifted majority vector.
module csa_3to2 #(
  parameter int W = 36
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s,
  output logic [W-1:0] cy
);

  assign s  = a ^ b ^ c;
  assign cy = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accumulator.sv
// csa_accumulator: framed carry-save accumulator with a chunked final carry-propagate add.
// Optional macro CSA_ACC_OVF_EN adds an ovf output flagging frames closed by the implied last.
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int N       = 32,
  parameter int MAX_OPS = 16,
  parameter int CHUNK   = 8,
  localparam int ACC_W  = acc_w(N, MAX_OPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in1,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum
`ifdef CSA_ACC_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W   = cnt_w(MAX_OPS);
  localparam int RES_CYC = res_cyc(ACC_W, CHUNK);
  localparam int PAD_W   = RES_CYC * CHUNK;
  localparam int K_W     = clog2(RES_CYC + 1);

  localparam logic [K_W-1:0]   K_LAST   = K_W'(RES_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_OPS - 1);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   s_q, c_q, x, s_nxt, cy;
  logic [CNT_W-1:0]   count_q;
  logic [K_W-1:0]     k_q;
  logic               carry_q;
  logic [PAD_W-1:0]   res_q, s_pad, c_pad;
  logic [CHUNK:0]     chunk_total;
  logic               implied_last;

  assign x            = ACC_W'(in1);
  assign implied_last = (count_q == CNT_LAST);

  csa_3to2 #(.W(ACC_W)) u_csa (
    .a  (s_q),
    .b  (c_q),
    .c  (x),
    .s  (s_nxt),
    .cy (cy)
  );

  // Zero padding above ACC_W masks the top chunk to the accumulator width.
  assign s_pad = PAD_W'(s_q);
  assign c_pad = PAD_W'(c_q);

  always_comb begin
    chunk_total = {1'b0, s_pad[k_q*CHUNK +: CHUNK]}
                + {1'b0, c_pad[k_q*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, carry_q};
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = in_last ? RESOLVE : ACC;
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && (in_last || implied_last)) state_d = RESOLVE;
      end
      RESOLVE: begin
        if (k_q == K_LAST) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      c_q     <= '0;
      count_q <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      sum     <= '0;
`ifdef CSA_ACC_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            s_q     <= x;
            c_q     <= '0;
            count_q <= CNT_W'(1);
            k_q     <= '0;
            carry_q <= 1'b0;
          end
        end
        ACC: begin
          if (in_valid) begin
            s_q     <= s_nxt;
            c_q     <= cy << 1;
            count_q <= count_q + CNT_W'(1);
`ifdef CSA_ACC_OVF_EN
            ovf     <= implied_last && !in_last;
`endif
          end
        end
        RESOLVE: begin
          if (k_q == K_LAST) begin
            sum <= ACC_W'(res_q);
          end else begin
            res_q[k_q*CHUNK +: CHUNK] <= chunk_total[CHUNK-1:0];
            carry_q                   <= chunk_total[CHUNK];
            k_q                       <= k_q + K_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            count_q <= '0;
`ifdef CSA_ACC_OVF_EN
            ovf     <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// tb_csa_accumulator: table-driven frames plus hand-written backpressure and reset sequences.
// Checks ovf as well when CSA_ACC_OVF_EN is defined.
module tb_csa_accumulator;

  localparam int N     = 32;
  localparam int ACC_W = 36;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in1;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] sum;
`ifdef CSA_ACC_OVF_EN
  logic             ovf;
`endif

  int passed = 0;
  int total  = 0;

  typedef struct {
    string              name;
    int                 n;
    bit                 last_on_final;
    bit                 gap;
    logic [15:0][31:0]  ops;
    logic [ACC_W-1:0]   exp_sum;
    bit                 exp_ovf;
  } vec_t;

  vec_t vecs [7];

  csa_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum)
`ifdef CSA_ACC_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] op, input logic last);
    int w;
    w        = 0;
    in_valid = 1'b1;
    in1      = op;
    in_last  = last;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    if (!in_ready) check("send_timeout", 64'd0, 64'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the frame's last accept edge.
  task automatic finish_frame(input string name, input logic [ACC_W-1:0] exp_sum,
                              input bit exp_ovf, input int hold_cycles);
    int               edges;
    bit               ir_low, stable;
    logic [ACC_W-1:0] held;
    edges  = 0;
    ir_low = 1'b1;
    stable = 1'b1;
    check({name, "_in_ready_after_last"}, 64'(in_ready), 64'd0);
    while (!out_valid && edges < 50) begin
      if (in_ready) ir_low = 1'b0;
      tick();
      edges++;
    end
    check({name, "_latency"}, 64'(edges), 64'd6);
    check({name, "_sum"}, 64'(sum), 64'(exp_sum));
`ifdef CSA_ACC_OVF_EN
    check({name, "_ovf"}, 64'(ovf), 64'(exp_ovf));
`else
    if (exp_ovf) ir_low = ir_low;
`endif
    held = sum;
    for (int i = 0; i < hold_cycles; i++) begin
      tick();
      if (sum !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    if (in_ready) ir_low = 1'b0;
    check({name, "_in_ready_low_until_handshake"}, 64'(ir_low), 64'd1);
    if (hold_cycles > 0) check({name, "_hold_stable"}, 64'(stable), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_out_valid_cleared"}, 64'(out_valid), 64'd0);
    check({name, "_in_ready_restored"}, 64'(in_ready), 64'd1);
`ifdef CSA_ACC_OVF_EN
    check({name, "_ovf_cleared"}, 64'(ovf), 64'd0);
`endif
  endtask

  task automatic set_vec(input int idx, input string name, input int n, input bit lof,
                         input bit gap, input logic [15:0][31:0] ops,
                         input logic [ACC_W-1:0] exp_sum, input bit exp_ovf);
    vecs[idx].name          = name;
    vecs[idx].n             = n;
    vecs[idx].last_on_final = lof;
    vecs[idx].gap           = gap;
    vecs[idx].ops           = ops;
    vecs[idx].exp_sum       = exp_sum;
    vecs[idx].exp_ovf       = exp_ovf;
  endtask

  initial begin
    set_vec(0, "single",          1, 1'b1, 1'b0, {16{32'hFFFF_FFFF}}, 36'h0_FFFF_FFFF, 1'b0);
    set_vec(1, "four",            4, 1'b1, 1'b0, {16{32'hFFFF_FFFF}}, 36'h3_FFFF_FFFC, 1'b0);
    set_vec(2, "sixteen_implied", 16, 1'b0, 1'b0, {16{32'hFFFF_FFFF}}, 36'hF_FFFF_FFF0, 1'b1);
    set_vec(3, "sixteen_last",    16, 1'b1, 1'b0, {16{32'hFFFF_FFFF}}, 36'hF_FFFF_FFF0, 1'b0);
    set_vec(4, "carry_gapped",    3, 1'b1, 1'b1,
            512'({32'h0000_0001, 32'h8000_0000, 32'h8000_0000}), 36'h1_0000_0001, 1'b0);
    set_vec(5, "mixed",           3, 1'b1, 1'b0,
            512'({32'h0F0F_0F0F, 32'h9ABC_DEF0, 32'h1234_5678}), 36'h0_BC00_4477, 1'b0);
    set_vec(6, "zeros",           2, 1'b1, 1'b1, '0, 36'h0, 1'b0);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in1       = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready",  64'(in_ready),  64'd1);
    check("reset_sum",       64'(sum),       64'd0);
`ifdef CSA_ACC_OVF_EN
    check("reset_ovf",       64'(ovf),       64'd0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        send(vecs[v].ops[i], vecs[v].last_on_final && (i == vecs[v].n - 1));
        if (vecs[v].gap && i < vecs[v].n - 1) begin
          tick();
          tick();
        end
      end
      finish_frame(vecs[v].name, vecs[v].exp_sum, vecs[v].exp_ovf, 0);
    end

    // Backpressure: hold out_ready low for 10 cycles, then the next frame follows.
    send(32'd7, 1'b0);
    send(32'd9, 1'b1);
    finish_frame("backpressure", 36'h10, 1'b0, 10);
    send(32'd5, 1'b1);
    finish_frame("after_backpressure", 36'h5, 1'b0, 0);

    // Reset pulse mid-RESOLVE: outputs return to reset values without a clock edge.
    send(32'hFFFF_FFFF, 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_sum",       64'(sum),       64'd0);
    check("midreset_in_ready",  64'(in_ready),  64'd1);
    #3;
    rst_n = 1'b1;
    tick();
    send(32'd3, 1'b0);
    send(32'd4, 1'b1);
    finish_frame("after_reset", 36'h7, 1'b0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x0, expected 0x1");
    $fatal(1, "simulation time limit reached");
  end

endmodule
